nand_op_sequencer: RTL
======================

# nand_op_sequencer

Multi-cycle controller that shares one physical 2-input NAND evaluation unit, a single `nand_gate`-style bitwise stage of width WIDTH, among NUM_REQ requesters. Each requester asks for a logic function (NAND, AND, OR, NOR, XOR, XNOR, NOT, BUF). The sequencer arbitrates round-robin and decomposes the function into a fixed sequence of NAND evaluations, one per clock. It returns the result with a one-cycle done pulse. It sits between gate-level requesters and the shared NAND resource, demonstrating universal-gate synthesis in time rather than in area.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 1, operand/result width; all ops bitwise
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  NUM_REQ  level request per requester
- op  input  3*NUM_REQ  opcode of requester i at op[3i+2:3i]
- A  input  WIDTH*NUM_REQ  operand A of requester i at A[WIDTH*i +: WIDTH]
- B  input  WIDTH*NUM_REQ  operand B of requester i, same packing
- gnt  output  NUM_REQ  one-hot, one-cycle pulse: operands of requester i captured
- done  output  NUM_REQ  one-hot, one-cycle pulse: result valid for requester i
- result  output  WIDTH  result of the last completed op; held until next completion
- busy  output  1  high whenever state is not IDLE

## Operation
- Opcodes and NAND step count K. Each step is nand(x,y) = ~(x&y) on the single shared unit; t1..t3 are internal WIDTH-bit temporaries.
  - 0 NAND, K=1: r=n(A,B)
  - 1 AND, K=2: t1=n(A,B); r=n(t1,t1)
  - 2 OR, K=3: t1=n(A,A); t2=n(B,B); r=n(t1,t2)
  - 3 NOR, K=4: the OR steps, then r=n(t3,t3)
  - 4 XOR, K=4: t1=n(A,B); t2=n(A,t1); t3=n(B,t1); r=n(t2,t3)
  - 5 XNOR, K=5: the XOR steps, then r=n(t,t)
  - 6 NOT A, K=1: r=n(A,A)
  - 7 BUF A, K=2: t1=n(A,A); r=n(t1,t1)
- Exactly one NAND evaluation per EXEC cycle; the shared unit is never driven by two requesters.
- FSM states:
  - IDLE: if any req bit is set, arbitrate, capture the winner's op/A/B and id, and go to EXEC. Otherwise stay.
  - EXEC: step counter runs 0..K-1. On the step K-1 edge, load result and go to DONE.
  - DONE: assert done[id], then go to IDLE.
- Arbitration is round-robin. The search starts at pointer `ptr` and wraps modulo NUM_REQ. After a grant, ptr = winner+1 (wraps).
- Operands and opcode need to be valid only in the IDLE cycle in which req is sampled. Later changes to them are ignored.
- req is a level signal. A requester must drop req[i] no later than the cycle done[i] is high. If req[i] is still high in the following IDLE cycle, it is a new request.
- Requests arriving during EXEC/DONE wait. They are not lost as long as req is held.

## Timing
- Reset values: state IDLE, gnt 0, done 0, result 0, busy 0, ptr 0, step counter 0, temporaries 0.
- Edge E0 (IDLE with req) leads to gnt[i] high for exactly the cycle after E0, with busy high from the same cycle.
- done[i] is high exactly K cycles after the gnt cycle. result changes on the same edge that raises done.
- Back-to-back: the next gnt comes 2 cycles after done (DONE cycle, then IDLE cycle). Per-op occupancy is K+2 cycles.
- Simultaneous requests are granted in round-robin order from ptr. After reset, requester 0 has top priority.
- Reset asserted mid-EXEC/DONE: all outputs clear asynchronously, the in-flight op is dropped, and no done is issued. After reset release, the first grant again starts search at 0.
- gnt and done are never high in the same cycle. At most one bit of each is set.

## Test plan
- Reset mid-op: assert rst_n=0 during EXEC -> gnt, done, busy and result are 0 immediately. Release, requester 0 issues NAND with A=4'b1111, B=4'b0011 -> result 4'b1100.
- XOR, single requester (WIDTH=4): req[1] with op=4, A=4'b1100, B=4'b1010 -> gnt=4'b0010 one cycle; done=4'b0010 exactly 4 cycles later; result=4'b0110.
- Full sweep: every opcode on requester 0 with A=4'b1100, B=4'b1010 -> NAND 0111, AND 1000, OR 1110, NOR 0001, XOR 0110, XNOR 1001, NOT 0011, BUF 1100. The gnt-to-done gap for each equals its K (1,2,3,4,4,5,1,2).
- Round-robin: req=4'b1111 held (each requester drops its req on its own done) -> grant order 0,1,2,3. Then req=4'b1001 -> grant order 0,3.
- Operand stability: after gnt, change A/B/op -> result still reflects the captured values. Changes made before sampling must be reflected.
- Held request: keep req[2]=1 across its done -> it is re-granted 2 cycles after done, with a second done pulse.

Source files
------------

// File: rtl/nand_op_sequencer.sv
// rtl/nand_op_sequencer.sv - round-robin sequencer time-sharing one WIDTH-bit NAND stage
module nand_op_sequencer #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [3*NUM_REQ-1:0]     op,
  input  logic [WIDTH*NUM_REQ-1:0] A,
  input  logic [WIDTH*NUM_REQ-1:0] B,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [WIDTH-1:0]         result,
  output logic                     busy
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
  state_t state, state_nxt;

  logic [IDW-1:0]   ptr, id, win, cand;
  logic             found;
  logic [2:0]       op_q, step, sel_op;
  logic [WIDTH-1:0] a_q, b_q, t1, t2, t3, nx, ny, nand_out, sel_a, sel_b;
  logic             last_step;
  int               idx;

  function automatic logic [2:0] last_step_of(input logic [2:0] opc);
    case (opc)
      3'd0, 3'd6: return 3'd0;
      3'd1, 3'd7: return 3'd1;
      3'd2:       return 3'd2;
      3'd3, 3'd4: return 3'd3;
      default:    return 3'd4;
    endcase
  endfunction

  // Round-robin search starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IDW'(i)) begin
        sel_op = op[3*i +: 3];
        sel_a  = A[WIDTH*i +: WIDTH];
        sel_b  = B[WIDTH*i +: WIDTH];
      end
    end
  end

  // Operand routing into the shared NAND for each (opcode, step) pair.
  always_comb begin
    nx = a_q;
    ny = b_q;
    case (op_q)
      3'd1: if (step != 3'd0) begin nx = t1; ny = t1; end
      3'd2, 3'd3: begin
        case (step)
          3'd0:    begin nx = a_q; ny = a_q; end
          3'd1:    begin nx = b_q; ny = b_q; end
          3'd2:    begin nx = t1;  ny = t2;  end
          default: begin nx = t3;  ny = t3;  end
        endcase
      end
      3'd4, 3'd5: begin
        case (step)
          3'd0:    begin nx = a_q; ny = b_q; end
          3'd1:    begin nx = a_q; ny = t1;  end
          3'd2:    begin nx = b_q; ny = t1;  end
          3'd3:    begin nx = t2;  ny = t3;  end
          default: begin nx = t1;  ny = t1;  end
        endcase
      end
      3'd6: begin nx = a_q; ny = a_q; end
      3'd7: begin
        if (step == 3'd0) begin nx = a_q; ny = a_q; end
        else begin nx = t1; ny = t1; end
      end
      default: begin nx = a_q; ny = b_q; end
    endcase
  end

  assign nand_out  = ~(nx & ny);
  assign last_step = (step == last_step_of(op_q));
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (found) state_nxt = S_EXEC;
      S_EXEC:  if (last_step) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt    <= '0;
      done   <= '0;
      result <= '0;
      ptr    <= '0;
      id     <= '0;
      op_q   <= '0;
      step   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      t1     <= '0;
      t2     <= '0;
      t3     <= '0;
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state)
        S_IDLE: if (found) begin
          gnt  <= NUM_REQ'(1) << win;
          id   <= win;
          op_q <= sel_op;
          a_q  <= sel_a;
          b_q  <= sel_b;
          step <= '0;
          ptr  <= (win == IDW'(NUM_REQ-1)) ? '0 : win + 1'b1;
        end
        S_EXEC: begin
          if (last_step) begin
            result <= nand_out;
            done   <= NUM_REQ'(1) << id;
            step   <= '0;
          end else begin
            step <= step + 3'd1;
            // XNOR's fourth step reuses t1, which is dead by then.
            case (step)
              3'd0:    t1 <= nand_out;
              3'd1:    t2 <= nand_out;
              3'd2:    t3 <= nand_out;
              default: t1 <= nand_out;
            endcase
          end
        end
        default: ;
      endcase
    end
  end
endmodule
